// File: rtl/crc32_4bit_fcs_check.sv
// crc32_4bit_fcs_check: receive-side CRC-32/BZIP2 FCS checker for an MSB-first nibble stream.
// Payload is forwarded through an 8-nibble delay line so the trailing FCS never reaches axiod.
module crc32_4bit_fcs_check #(
    parameter logic [31:0] MAGIC       = 32'h38FB2284,
    parameter int          MIN_NIBBLES = 16,
    parameter int          CNT_W       = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             axiiv,
    input  logic [3:0]       axiid,
    output logic             axiov,
    output logic [3:0]       axiod,
    output logic             done,
    output logic             ok,
    output logic [CNT_W-1:0] len
);
    localparam logic [31:0]      POLY    = 32'h04C11DB7;
    localparam logic [31:0]      INIT    = 32'hFFFFFFFF;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(MIN_NIBBLES);
    localparam logic [CNT_W-1:0] FCS_NIB = CNT_W'(8);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    typedef enum logic {IDLE, FRAME} state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic [31:0]      r_lfsr;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_dl [8];
    logic [3:0]       r_fill;
    logic [31:0]      w_lfsr_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] w_len;
    logic             w_end;
    logic             w_good;

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [3:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 3; i >= 0; i--) begin
            if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ POLY;
            else              r = {r[30:0], 1'b0};
        end
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (axiiv)  w_state_next = FRAME;
            FRAME:   if (!axiiv) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // A frame's first nibble always starts from the init value, whatever the register holds.
    always_comb begin
        w_lfsr_next = crc_step((r_state == IDLE) ? INIT : r_lfsr, axiid);
        w_cnt_next  = (r_state == IDLE) ? CNT_ONE :
                      (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;
        w_end       = (r_state == FRAME) && !axiiv;
        w_good      = (~r_lfsr == MAGIC) && (r_cnt >= CNT_MIN) && !r_cnt[0] && (r_cnt != CNT_MAX);
        w_len       = (r_cnt > FCS_NIB) ? r_cnt - FCS_NIB : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= INIT;
            r_cnt  <= '0;
            r_fill <= '0;
            for (int i = 0; i < 8; i++) r_dl[i] <= '0;
            axiov  <= 1'b0;
            axiod  <= '0;
            done   <= 1'b0;
            ok     <= 1'b0;
            len    <= '0;
        end else begin
            axiov <= 1'b0;
            done  <= 1'b0;
            ok    <= 1'b0;
            if (axiiv) begin
                r_lfsr  <= w_lfsr_next;
                r_cnt   <= w_cnt_next;
                r_dl[0] <= axiid;
                for (int i = 1; i < 8; i++) r_dl[i] <= r_dl[i-1];
                // Once full, the nibble falling off the end is payload, never FCS.
                if (r_fill == 4'd8) begin
                    axiov <= 1'b1;
                    axiod <= r_dl[7];
                end else begin
                    r_fill <= r_fill + 4'd1;
                end
            end else if (w_end) begin
                done   <= 1'b1;
                ok     <= w_good;
                len    <= w_len;
                r_lfsr <= INIT;
                r_cnt  <= '0;
                r_fill <= '0;
            end
        end
    end
endmodule

// File: tb/tb_crc32_4bit_fcs_check.sv
// Self-checking bench for crc32_4bit_fcs_check: table of directed/random frames checked
// against a polynomial-division reference model, plus back-to-back and mid-frame reset sequences.
module tb_crc32_4bit_fcs_check;
    localparam int          CNT_W  = 12;
    localparam int          CNT_SAT = (1 << CNT_W) - 1;
    localparam logic [31:0] MAGIC  = 32'h38FB2284;

    logic             clk = 1'b0;
    logic             rst;
    logic             axiiv;
    logic [3:0]       axiid;
    logic             axiov;
    logic [3:0]       axiod;
    logic             done;
    logic             ok;
    logic [CNT_W-1:0] len;

    crc32_4bit_fcs_check #(.MAGIC(MAGIC), .MIN_NIBBLES(16), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .axiiv(axiiv), .axiid(axiid),
        .axiov(axiov), .axiod(axiod), .done(done), .ok(ok), .len(len)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int xerr     = 0;
    bit armed    = 0;

    logic [3:0]     beats[$];
    logic [CNT_W:0] dones[$];
    logic [3:0]     frm[$];

    always @(negedge clk) begin
        if (armed && !rst) begin
            if ($isunknown({axiov, axiod, done, ok, len})) xerr++;
            if (axiov) beats.push_back(axiod);
            if (done)  dones.push_back({ok, len});
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // CRC register value as remainder of (M(x)*x^32 + INIT*x^n) mod P, by long division.
    function automatic logic [31:0] lfsr_after(input logic [3:0] q[$]);
        int          n = q.size() * 4;
        int          L = q.size() * 4 + 32;
        bit          b[];
        logic [32:0] p33;
        logic [31:0] r;
        p33 = 33'h104C11DB7;
        b = new[L];
        for (int i = 0; i < q.size(); i++)
            for (int k = 0; k < 4; k++) b[i*4+k] = q[i][3-k];
        for (int j = 0; j < 32; j++) b[j] = b[j] ^ 1'b1;
        for (int j = 0; j + 32 < L; j++)
            if (b[j]) for (int k = 0; k < 33; k++) b[j+k] = b[j+k] ^ p33[32-k];
        for (int k = 0; k < 32; k++) r[31-k] = b[L-32+k];
        if (n < 0) r = '0;
        return r;
    endfunction

    function automatic void model(input logic [3:0] q[$], output logic mok, output int mlen);
        int cnt;
        cnt  = (q.size() > CNT_SAT) ? CNT_SAT : q.size();
        mok  = (~lfsr_after(q) == MAGIC) && (cnt >= 16) && (cnt % 2 == 0) && (cnt < CNT_SAT);
        mlen = (cnt > 8) ? cnt - 8 : 0;
    endfunction

    task automatic append_fcs();
        logic [31:0] fcs;
        fcs = ~lfsr_after(frm);
        for (int i = 7; i >= 0; i--) frm.push_back(fcs[i*4 +: 4]);
    endtask

    task automatic build(input int mode, input int plen);
        logic [63:0] msg;
        logic [31:0] fcs;
        msg = 64'h676960D19D785A5B;
        fcs = 32'h96CB5E37;
        frm.delete();
        case (mode)
            0, 1, 3: begin
                for (int i = 15; i >= 0; i--) frm.push_back(msg[i*4 +: 4]);
                for (int i = 7; i >= 0; i--)  frm.push_back(fcs[i*4 +: 4]);
                if (mode == 1) frm[5] = frm[5] ^ 4'h1;
                if (mode == 3) frm.push_back(4'h0);
            end
            2: for (int i = 0; i < 8; i++) frm.push_back(4'hA);
            4: begin
                for (int i = 0; i < plen; i++) frm.push_back(4'($urandom_range(0, 15)));
                append_fcs();
            end
            default: for (int i = 0; i < plen + 8; i++) frm.push_back(4'($urandom_range(0, 15)));
        endcase
    endtask

    task automatic send(input int n, input bit close);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            axiiv = 1'b1;
            axiid = frm[i];
        end
        if (close) begin
            @(posedge clk); #1;
            axiiv = 1'b0;
        end
    endtask

    task automatic check_beats(input string nm, input int nframes);
        int plen;
        int bad;
        plen = (frm.size() > 8) ? frm.size() - 8 : 0;
        bad  = 0;
        check({nm, "_beat_count"}, beats.size(), plen * nframes);
        for (int i = 0; i < beats.size() && i < plen * nframes; i++)
            if (beats[i] !== frm[i % plen]) bad++;
        check({nm, "_beat_data_errs"}, bad, 0);
    endtask

    task automatic run_frame(input string nm, input int exp_ok, input int exp_len);
        logic mok;
        int   mlen;
        int   eok;
        int   elen;
        model(frm, mok, mlen);
        eok  = (exp_ok >= 0) ? exp_ok : int'(mok);
        elen = (exp_len >= 0) ? exp_len : mlen;
        beats.delete();
        dones.delete();
        send(frm.size(), 1'b1);
        repeat (3) @(negedge clk);
        check({nm, "_done_pulses"}, dones.size(), 1);
        if (dones.size() >= 1) begin
            check({nm, "_ok"},  dones[0][CNT_W], eok);
            check({nm, "_len"}, dones[0][CNT_W-1:0], elen);
        end
        check_beats(nm, 1);
    endtask

    typedef struct {
        string name;
        int    mode;
        int    plen;
        int    exp_ok;
        int    exp_len;
    } vec_t;

    initial begin
        vec_t vecs[$];
        logic mok;
        int   mlen;

        vecs.push_back('{"good",      0, 0,    -1, 16});
        vecs.push_back('{"bad_nib5",  1, 0,     0, 16});
        vecs.push_back('{"short8",    2, 0,     0,  0});
        vecs.push_back('{"odd25",     3, 0,     0, 17});
        vecs.push_back('{"rnd_good8", 4, 8,     1,  8});
        vecs.push_back('{"rnd_good0", 4, 0,     0,  0});
        for (int i = 0; i < 6; i++)
            vecs.push_back('{$sformatf("rnd_good_%0d", i), 4, int'($urandom_range(0, 40)), -1, -1});
        for (int i = 0; i < 4; i++)
            vecs.push_back('{$sformatf("rnd_junk_%0d", i), 5, int'($urandom_range(0, 30)), -1, -1});
        vecs.push_back('{"saturate",  4, 4092,  0, CNT_SAT - 8});

        rst = 1'b1; axiiv = 1'b0; axiid = 4'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {axiov, axiod, done, ok, len}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        armed = 1'b1;

        foreach (vecs[v]) begin
            build(vecs[v].mode, vecs[v].plen);
            run_frame(vecs[v].name, vecs[v].exp_ok, vecs[v].exp_len);
        end

        // Back-to-back frames with the minimum single idle cycle between them.
        build(0, 0);
        model(frm, mok, mlen);
        beats.delete();
        dones.delete();
        send(frm.size(), 1'b1);
        send(frm.size(), 1'b1);
        repeat (3) @(negedge clk);
        check("b2b_done_pulses", dones.size(), 2);
        if (dones.size() == 2) begin
            check("b2b_ok0",  dones[0][CNT_W], mok);
            check("b2b_ok1",  dones[1][CNT_W], mok);
            check("b2b_len1", dones[1][CNT_W-1:0], 16);
        end
        check_beats("b2b", 2);

        // Reset in the middle of a frame, then resend it intact.
        build(0, 0);
        beats.delete();
        dones.delete();
        send(12, 1'b0);
        @(posedge clk); #1;
        rst = 1'b1;
        axiiv = 1'b0;
        @(negedge clk);
        check("midrst_outputs_a", {axiov, axiod, done, ok, len}, '0);
        repeat (2) @(negedge clk);
        check("midrst_outputs_b", {axiov, axiod, done, ok, len}, '0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("midrst_no_done", dones.size(), 0);
        run_frame("resent", -1, 16);

        check("no_x_outputs", xerr, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
